// File: rtl/proc_io_pkg.sv
// Shared constants, error causes and helpers for the processor I/O bridge.
package proc_io_pkg;

   localparam int NCH_MIN   = 2;
   localparam int NCH_MAX   = 16;
   localparam int DEPTH_MIN = 2;

   typedef enum logic [0:0] {
      BAD_ADDR = 1'b0,
      TIMEOUT  = 1'b1
   } err_cause_e;

   function automatic int addr_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/io_fifo.sv
// Show-ahead FIFO: dout is always the head; push when full and pop when empty are ignored.
module io_fifo #(
   parameter int DW    = 19,
   parameter int DEPTH = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic [DW-1:0] din,
   input  logic          pop,
   output logic [DW-1:0] dout,
   output logic          full,
   output logic          empty
);

   localparam int PW = $clog2(DEPTH);

   logic [DW-1:0] r_mem [DEPTH];
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [PW:0]   r_count;
   logic          w_push;
   logic          w_pop;

   assign full   = (r_count == (PW+1)'(DEPTH));
   assign empty  = (r_count == '0);
   assign w_push = push & ~full;
   assign w_pop  = pop & ~empty;
   assign dout   = r_mem[r_rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         r_count <= r_count + (PW+1)'(w_push) - (PW+1)'(w_pop);
      end
   end

   // Storage is left unreset; only the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= din;
   end

endmodule

// File: rtl/proc_io_bridge.sv
// Per-channel FIFO bridge between external integer streams and the processor strobe port.
// Optional stall timeout enabled by defining PROC_IO_TIMEOUT_EN.
module proc_io_bridge
   import proc_io_pkg::*;
#(
   parameter int NCH   = 4,
   parameter int DW    = 19,
   parameter int DEPTH = 4,
   parameter int TMO   = 1023,
   parameter int AW    = addr_width(NCH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NCH*DW-1:0] in_data,
   input  logic [NCH-1:0]    in_valid,
   output logic [NCH-1:0]    in_ready,
   output logic [NCH*DW-1:0] out_data,
   output logic [NCH-1:0]    out_valid,
   input  logic [NCH-1:0]    out_ready,
   input  logic              proc_req_in,
   input  logic [AW-1:0]     proc_addr_in,
   output logic [DW-1:0]     proc_din,
   input  logic              proc_out_en,
   input  logic [AW-1:0]     proc_addr_out,
   input  logic [DW-1:0]     proc_dout,
   output logic              proc_stall,
   output logic [NCH-1:0]    req_in,
   output logic [NCH-1:0]    out_en,
   output logic              err
);

   if (NCH < NCH_MIN || NCH > NCH_MAX || DEPTH < DEPTH_MIN ||
       (DEPTH & (DEPTH - 1)) != 0 || TMO < 1) begin : g_param_check
      $error("proc_io_bridge: illegal parameter set");
   end

   logic [NCH-1:0] w_in_full,  w_in_empty,  w_in_push,  w_in_pop;
   logic [NCH-1:0] w_out_full, w_out_empty, w_out_push, w_out_pop;
   logic [DW-1:0]  w_in_head [NCH];

   logic [NCH-1:0] w_rd_sel, w_wr_sel;
   logic [DW-1:0]  w_rd_head;
   logic           w_rd_empty, w_wr_full;
   logic           w_rd_ok, w_wr_ok;
   logic           w_rd_blk, w_wr_blk, w_blk;
   logic           w_force, w_stall;
   logic           w_rd_commit, w_wr_commit;
   logic [1:0]     w_cause;
   logic           r_err;

   // Address decode is a compare loop so out-of-range addresses simply select nothing.
   always_comb begin
      w_rd_sel   = '0;
      w_wr_sel   = '0;
      w_rd_head  = '0;
      w_rd_empty = 1'b1;
      w_wr_full  = 1'b0;
      for (int k = 0; k < NCH; k++) begin
         if (proc_addr_in == AW'(k)) begin
            w_rd_sel[k] = 1'b1;
            w_rd_head   = w_in_head[k];
            w_rd_empty  = w_in_empty[k];
         end
         if (proc_addr_out == AW'(k)) begin
            w_wr_sel[k] = 1'b1;
            w_wr_full   = w_out_full[k];
         end
      end
   end

   assign w_rd_ok  = |w_rd_sel;
   assign w_wr_ok  = |w_wr_sel;
   assign w_rd_blk = proc_req_in & w_rd_ok & w_rd_empty;
   assign w_wr_blk = proc_out_en & w_wr_ok & w_wr_full;
   assign w_blk    = w_rd_blk | w_wr_blk;

`ifdef PROC_IO_TIMEOUT_EN
   localparam int TW = $clog2(TMO + 1);
   logic [TW-1:0] r_stall_cnt;

   assign w_force = w_blk & (r_stall_cnt == TW'(TMO));

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                  r_stall_cnt <= '0;
      else if (w_blk & ~w_force) r_stall_cnt <= r_stall_cnt + 1'b1;
      else                      r_stall_cnt <= '0;
   end
`else
   assign w_force = 1'b0;
`endif

   assign w_stall     = ~rst & w_blk & ~w_force;
   assign w_rd_commit = ~rst & proc_req_in & w_rd_ok & ~w_rd_empty & ~w_stall;
   assign w_wr_commit = ~rst & proc_out_en & w_wr_ok & ~w_wr_full & ~w_stall;

   assign proc_stall = w_stall;
   assign proc_din   = (~rst & w_rd_ok & ~w_rd_empty) ? w_rd_head : '0;
   assign req_in     = w_rd_commit ? w_rd_sel : '0;
   assign out_en     = w_wr_commit ? w_wr_sel : '0;

   assign in_ready   = ~w_in_full & {NCH{~rst}};
   assign out_valid  = ~w_out_empty;
   assign w_in_push  = in_valid & in_ready;
   assign w_in_pop   = req_in;
   assign w_out_push = out_en;
   assign w_out_pop  = out_valid & out_ready;

   assign w_cause[BAD_ADDR] = (proc_req_in & ~w_rd_ok) | (proc_out_en & ~w_wr_ok);
   assign w_cause[TIMEOUT]  = w_force;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)           r_err <= 1'b0;
      else if (|w_cause) r_err <= 1'b1;
   end

   assign err = r_err;

   for (genvar k = 0; k < NCH; k++) begin : g_ch
      io_fifo #(.DW(DW), .DEPTH(DEPTH)) u_in_fifo (
         .clk   (clk),
         .rst   (rst),
         .push  (w_in_push[k]),
         .din   (in_data[k*DW +: DW]),
         .pop   (w_in_pop[k]),
         .dout  (w_in_head[k]),
         .full  (w_in_full[k]),
         .empty (w_in_empty[k])
      );

      io_fifo #(.DW(DW), .DEPTH(DEPTH)) u_out_fifo (
         .clk   (clk),
         .rst   (rst),
         .push  (w_out_push[k]),
         .din   (proc_dout),
         .pop   (w_out_pop[k]),
         .dout  (out_data[k*DW +: DW]),
         .full  (w_out_full[k]),
         .empty (w_out_empty[k])
      );
   end

endmodule
